i2s_transmitter: RTL

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

---
 rtl/i2s_transmitter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/i2s_transmitter.sv
// I2S transmitter: 8-bit left/right samples arrive through valid/ready ports
// and are sent MSB first, one SCK after each slot edge, in SLOT_BITS-wide slots.
module i2s_transmitter #(
  parameter int unsigned SCK_HALF  = 4,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] s_axis_tdata_l,
  input  logic       s_axis_tvalid_l,
  output logic       s_axis_tready_l,
  input  logic [7:0] s_axis_tdata_r,
  input  logic       s_axis_tvalid_r,
  output logic       s_axis_tready_r,
  output logic       MCLK,
  output logic       SCK,
  output logic       LRCLK,
  output logic       SDATA,
  output logic       underrun_l,
  output logic       underrun_r
);

  localparam int unsigned DIV_W = $clog2(SCK_HALF);
  localparam int unsigned BIT_W = $clog2(SLOT_BITS);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             mclk_q, mclk_d, sck_q, sck_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
  logic [7:0]       shift_q, shift_d, hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic             full_l_q, full_l_d, full_r_q, full_r_d;
  logic             tready_l_q, tready_l_d, tready_r_q, tready_r_d;
  logic             underrun_l_q, underrun_l_d, underrun_r_q, underrun_r_d;
  logic             fall_evt, slot_start;
  logic [2:0]       bit_sel;

  always_comb begin
    mclk_d       = ~mclk_q;
    div_d        = div_q;
    sck_d        = sck_q;
    bit_cnt_d    = bit_cnt_q;
    lrclk_d      = lrclk_q;
    sdata_d      = sdata_q;
    shift_d      = shift_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    full_l_d     = full_l_q;
    full_r_d     = full_r_q;
    underrun_l_d = 1'b0;
    underrun_r_d = 1'b0;
    fall_evt     = 1'b0;
    bit_sel      = 3'd0;

    if (div_q == DIV_W'(SCK_HALF - 1)) begin
      div_d    = '0;
      sck_d    = ~sck_q;
      fall_evt = sck_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    slot_start = fall_evt && (bit_cnt_q == BIT_W'(SLOT_BITS - 1));

    if (fall_evt) begin
      bit_cnt_d = slot_start ? '0 : bit_cnt_q + BIT_W'(1);
      if (slot_start) begin
        lrclk_d = ~lrclk_q;
        // lrclk_q high means the new slot is the left one
        if (lrclk_q) begin
          shift_d      = full_l_q ? hold_l_q : 8'h00;
          underrun_l_d = ~full_l_q;
          full_l_d     = 1'b0;
        end else begin
          shift_d      = full_r_q ? hold_r_q : 8'h00;
          underrun_r_d = ~full_r_q;
          full_r_d     = 1'b0;
        end
      end
      bit_sel = 3'(4'd8 - 4'(bit_cnt_d));
      sdata_d = (bit_cnt_d >= BIT_W'(1) && bit_cnt_d <= BIT_W'(8)) ? shift_q[bit_sel] : 1'b0;
    end

    // Captures come after the slot load so a same-cycle load sees the empty register
    if (s_axis_tvalid_l && tready_l_q) begin
      hold_l_d = s_axis_tdata_l;
      full_l_d = 1'b1;
    end
    if (s_axis_tvalid_r && tready_r_q) begin
      hold_r_d = s_axis_tdata_r;
      full_r_d = 1'b1;
    end

    tready_l_d = ~full_l_d;
    tready_r_d = ~full_r_d;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mclk_q       <= 1'b0;
      div_q        <= '0;
      sck_q        <= 1'b0;
      bit_cnt_q    <= BIT_W'(SLOT_BITS - 1);
      lrclk_q      <= 1'b1;
      sdata_q      <= 1'b0;
      shift_q      <= 8'h00;
      hold_l_q     <= 8'h00;
      hold_r_q     <= 8'h00;
      full_l_q     <= 1'b0;
      full_r_q     <= 1'b0;
      tready_l_q   <= 1'b0;
      tready_r_q   <= 1'b0;
      underrun_l_q <= 1'b0;
      underrun_r_q <= 1'b0;
    end else begin
      mclk_q       <= mclk_d;
      div_q        <= div_d;
      sck_q        <= sck_d;
      bit_cnt_q    <= bit_cnt_d;
      lrclk_q      <= lrclk_d;
      sdata_q      <= sdata_d;
      shift_q      <= shift_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      full_l_q     <= full_l_d;
      full_r_q     <= full_r_d;
      tready_l_q   <= tready_l_d;
      tready_r_q   <= tready_r_d;
      underrun_l_q <= underrun_l_d;
      underrun_r_q <= underrun_r_d;
    end
  end

  assign MCLK            = mclk_q;
  assign SCK             = sck_q;
  assign LRCLK           = lrclk_q;
  assign SDATA           = sdata_q;
  assign underrun_l      = underrun_l_q;
  assign underrun_r      = underrun_r_q;
  assign s_axis_tready_l = tready_l_q;
  assign s_axis_tready_r = tready_r_q;

endmodule
